msi_line_ctrl: RTL

Parametrised MSI data-cache controller with embedded direct-mapped tag, state and data arrays. It sits between one core's load/store port and the shared snooping bus and unified memory. Compared with the previous single-size controller, it adds:
- configurable word width, line size and set count;
- explicit BusRd/BusRdX/BusUpgr bus commands behind a request/grant handshake;
- snoop-driven flush of Modified lines;
- saturating hit/miss counters.

---
 rtl/msi_line_ctrl_if.sv | 54 +++++
 rtl/msi_line_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/msi_line_ctrl_if.sv
// rtl/msi_line_ctrl_if.sv - Core, snooping bus, memory and statistics signals of msi_line_ctrl
interface msi_line_ctrl_if #(
    parameter int ADDR_W     = 13,
    parameter int WORD_W     = 16,
    parameter int LINE_WORDS = 4,
    parameter int CNT_W      = 16
);
    localparam int OFF_W  = $clog2(LINE_WORDS);
    localparam int LA_W   = ADDR_W - OFF_W;
    localparam int LINE_W = WORD_W * LINE_WORDS;

    logic [ADDR_W-1:0] cpu_addr;
    logic [WORD_W-1:0] cpu_wdata;
    logic              cpu_re;
    logic              cpu_we;
    logic [WORD_W-1:0] cpu_rdata;
    logic              cpu_rdy;

    logic              bus_req;
    logic              bus_gnt;
    logic [1:0]        bus_cmd;
    logic [LA_W-1:0]   bus_addr;

    logic              mem_re;
    logic              mem_we;
    logic [LA_W-1:0]   mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_rdy;

    logic              snp_valid;
    logic [1:0]        snp_cmd;
    logic [LA_W-1:0]   snp_addr;
    logic              snp_hit;
    logic              snp_flush;
    logic [LINE_W-1:0] snp_data;

    logic [CNT_W-1:0]  stat_hits;
    logic [CNT_W-1:0]  stat_misses;

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_re, cpu_we, bus_gnt, mem_rdata, mem_rdy,
               snp_valid, snp_cmd, snp_addr,
        output cpu_rdata, cpu_rdy, bus_req, bus_cmd, bus_addr, mem_re, mem_we, mem_addr,
               mem_wdata, snp_hit, snp_flush, snp_data, stat_hits, stat_misses
    );

    modport master (
        output cpu_addr, cpu_wdata, cpu_re, cpu_we, bus_gnt, mem_rdata, mem_rdy,
               snp_valid, snp_cmd, snp_addr,
        input  cpu_rdata, cpu_rdy, bus_req, bus_cmd, bus_addr, mem_re, mem_we, mem_addr,
               mem_wdata, snp_hit, snp_flush, snp_data, stat_hits, stat_misses
    );
endinterface

// File: rtl/msi_line_ctrl.sv
// rtl/msi_line_ctrl.sv - Direct-mapped MSI data-cache controller with snoop flush and hit/miss counters
module msi_line_ctrl #(
    parameter int ADDR_W     = 13,
    parameter int WORD_W     = 16,
    parameter int LINE_WORDS = 4,
    parameter int SETS       = 64,
    parameter int CNT_W      = 16
) (
    input  logic           clk,
    input  logic           rst,
    msi_line_ctrl_if.slave bif
);
    localparam int OFF_W  = $clog2(LINE_WORDS);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
    localparam int LINE_W = WORD_W * LINE_WORDS;
    localparam int LA_W   = ADDR_W - OFF_W;

    localparam logic [1:0] CMD_NONE = 2'b00;
    localparam logic [1:0] CMD_RD   = 2'b01;
    localparam logic [1:0] CMD_RDX  = 2'b10;
    localparam logic [1:0] CMD_UPG  = 2'b11;

    typedef enum logic [1:0] {ST_I, ST_S, ST_M} line_st_t;
    typedef enum logic [2:0] {IDLE, ARB, UPG, WB, FILL} fsm_t;

    fsm_t             r_fsm;
    logic             r_pend_wr;
    logic             r_upgrade;
    logic [CNT_W-1:0] r_hits;
    logic [CNT_W-1:0] r_misses;

    line_st_t          r_st   [SETS];
    logic [TAG_W-1:0]  r_tag  [SETS];
    logic [LINE_W-1:0] r_data [SETS];

    logic [OFF_W-1:0]  w_off;
    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic [LA_W-1:0]   w_req_la;
    line_st_t          w_cur_st;
    logic [TAG_W-1:0]  w_cur_tag;
    logic [LINE_W-1:0] w_cur_line;
    logic [WORD_W-1:0] w_cur_word;
    logic [WORD_W-1:0] w_fill_word;
    logic              w_hit;

    assign w_off       = bif.cpu_addr[OFF_W-1:0];
    assign w_idx       = bif.cpu_addr[OFF_W +: IDX_W];
    assign w_tag       = bif.cpu_addr[ADDR_W-1 -: TAG_W];
    assign w_req_la    = bif.cpu_addr[ADDR_W-1:OFF_W];
    assign w_cur_st    = r_st[w_idx];
    assign w_cur_tag   = r_tag[w_idx];
    assign w_cur_line  = r_data[w_idx];
    assign w_cur_word  = w_cur_line[int'(w_off)*WORD_W +: WORD_W];
    assign w_fill_word = bif.mem_rdata[int'(w_off)*WORD_W +: WORD_W];
    assign w_hit       = (w_cur_st != ST_I) && (w_cur_tag == w_tag);

    logic [IDX_W-1:0] w_snp_idx;
    logic [TAG_W-1:0] w_snp_tag;
    line_st_t         w_snp_cur;
    logic             w_snp_match;
    logic             w_snp_flush;
    logic             w_snp_we;
    line_st_t         w_snp_st;

    assign w_snp_idx   = bif.snp_addr[IDX_W-1:0];
    assign w_snp_tag   = bif.snp_addr[LA_W-1 -: TAG_W];
    assign w_snp_cur   = r_st[w_snp_idx];
    assign w_snp_match = bif.snp_valid && (w_snp_cur != ST_I) && (r_tag[w_snp_idx] == w_snp_tag);
    assign w_snp_flush = w_snp_match && (w_snp_cur == ST_M) &&
                         ((bif.snp_cmd == CMD_RD) || (bif.snp_cmd == CMD_RDX));

    always_comb begin
        w_snp_we = 1'b0;
        w_snp_st = ST_I;
        if (w_snp_match) begin
            case (bif.snp_cmd)
                CMD_RD:  if (w_snp_cur == ST_M) begin w_snp_we = 1'b1; w_snp_st = ST_S; end
                CMD_RDX: w_snp_we = 1'b1;
                CMD_UPG: if (w_snp_cur == ST_S) w_snp_we = 1'b1;
                default: w_snp_we = 1'b0;
            endcase
        end
    end

    // Any snoop on the request's set defers the whole IDLE decision by a cycle.
    logic w_coll;
    logic w_idle_act;
    logic w_idle_done;
    logic w_idle_miss;
    logic w_idle_upg;
    logic w_wb_done;
    logic w_fill_done;

    assign w_coll      = bif.snp_valid && (w_snp_idx == w_idx);
    assign w_idle_act  = (r_fsm == IDLE) && (bif.cpu_re || bif.cpu_we) && !w_coll;
    assign w_idle_done = w_idle_act && w_hit && (bif.cpu_re || (w_cur_st == ST_M));
    assign w_idle_miss = w_idle_act && !w_hit;
    assign w_idle_upg  = w_idle_act && w_hit && bif.cpu_we && (w_cur_st == ST_S);
    assign w_wb_done   = (r_fsm == WB) && bif.mem_rdy;
    assign w_fill_done = (r_fsm == FILL) && bif.mem_rdy;

    logic              w_dat_we;
    logic              w_merge;
    logic [LINE_W-1:0] w_dat_line;
    logic              w_st_we;
    line_st_t          w_st_val;

    always_comb begin
        w_dat_we   = 1'b0;
        w_merge    = 1'b0;
        w_st_we    = 1'b0;
        w_st_val   = ST_I;
        w_dat_line = (r_fsm == FILL) ? bif.mem_rdata : w_cur_line;
        if (w_idle_done && bif.cpu_we) begin
            w_dat_we = 1'b1;
            w_merge  = 1'b1;
        end
        if (r_fsm == UPG) begin
            w_dat_we = 1'b1;
            w_merge  = 1'b1;
            w_st_we  = 1'b1;
            w_st_val = ST_M;
        end
        if (w_wb_done) begin
            w_st_we  = 1'b1;
            w_st_val = ST_I;
        end
        if (w_fill_done) begin
            w_dat_we = 1'b1;
            w_merge  = r_pend_wr;
            w_st_we  = 1'b1;
            w_st_val = r_pend_wr ? ST_M : ST_S;
        end
        if (w_merge) w_dat_line[int'(w_off)*WORD_W +: WORD_W] = bif.cpu_wdata;
    end

    // Snoop update first so a same-edge FSM write to the same entry overrides it.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SETS; i++) r_st[i] <= ST_I;
        end else begin
            if (w_snp_we) r_st[w_snp_idx] <= w_snp_st;
            if (w_st_we)  r_st[w_idx]     <= w_st_val;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_dat_we)    r_data[w_idx] <= w_dat_line;
        if (!rst && w_fill_done) r_tag[w_idx]  <= w_tag;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm     <= IDLE;
            r_pend_wr <= 1'b0;
            r_upgrade <= 1'b0;
            r_hits    <= '0;
            r_misses  <= '0;
        end else begin
            if (w_idle_done && (r_hits != '1))   r_hits   <= r_hits + 1'b1;
            if (w_idle_miss && (r_misses != '1)) r_misses <= r_misses + 1'b1;
            case (r_fsm)
                IDLE: if (w_idle_miss || w_idle_upg) begin
                    r_fsm     <= ARB;
                    r_upgrade <= w_idle_upg;
                    r_pend_wr <= bif.cpu_we;
                end
                ARB: if (bif.bus_gnt) begin
                    if (r_upgrade && w_hit && (w_cur_st == ST_S)) begin
                        r_fsm <= UPG;
                    end else if (r_upgrade) begin
                        r_fsm     <= FILL;
                        r_pend_wr <= 1'b1;
                    end else if (w_cur_st == ST_M) begin
                        r_fsm <= WB;
                    end else begin
                        r_fsm <= FILL;
                    end
                end
                UPG:     r_fsm <= IDLE;
                WB:      if (bif.mem_rdy) r_fsm <= FILL;
                FILL:    if (bif.mem_rdy) r_fsm <= IDLE;
                default: r_fsm <= IDLE;
            endcase
        end
    end

    assign bif.bus_req   = (r_fsm != IDLE);
    assign bif.bus_cmd   = (r_fsm == UPG)  ? CMD_UPG :
                           (r_fsm == FILL) ? (r_pend_wr ? CMD_RDX : CMD_RD) : CMD_NONE;
    assign bif.bus_addr  = ((r_fsm == UPG) || (r_fsm == FILL)) ? w_req_la : '0;
    assign bif.mem_re    = (r_fsm == FILL);
    assign bif.mem_we    = (r_fsm == WB);
    assign bif.mem_addr  = (r_fsm == WB)   ? {w_cur_tag, w_idx} :
                           (r_fsm == FILL) ? w_req_la : '0;
    assign bif.mem_wdata = (r_fsm == WB) ? w_cur_line : '0;
    assign bif.cpu_rdy   = w_idle_done || (r_fsm == UPG) || w_fill_done;
    assign bif.cpu_rdata = w_fill_done ? w_fill_word : (bif.cpu_rdy ? w_cur_word : '0);

    assign bif.snp_hit     = w_snp_match;
    assign bif.snp_flush   = w_snp_flush;
    assign bif.snp_data    = w_snp_flush ? r_data[w_snp_idx] : '0;
    assign bif.stat_hits   = r_hits;
    assign bif.stat_misses = r_misses;
endmodule
